// File: rtl/xcorr_pkg.sv
// rtl/xcorr_pkg.sv - shared constants, types and FSM encoding for the correlation peak finder
package xcorr_pkg;

    localparam int XCORR_W    = 31;
    localparam int MAX_DELAY  = 11;
    localparam int NUM_XCORRS = 6;
    localparam int NUM_LAGS   = 2*MAX_DELAY + 1;

    function automatic int lag_width(input int max_delay);
        return $clog2(max_delay + 1) + 1;
    endfunction

    localparam int LAG_W = lag_width(MAX_DELAY);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    typedef logic signed [NUM_LAGS-1:0][XCORR_W-1:0] xcorr_vec_t;

endpackage

// File: rtl/xcorr_argmax_lane.sv
// rtl/xcorr_argmax_lane.sv - one pair's snapshot plus running argmax over the shared lag index
module xcorr_argmax_lane
    import xcorr_pkg::*;
#(
    parameter int DATA_W    = XCORR_W,
    parameter int DELAY     = MAX_DELAY,
    parameter int LAG_OUT_W = lag_width(DELAY),
    parameter int N_LAGS    = 2*DELAY + 1,
    parameter int IX_W      = $clog2(N_LAGS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic                        scan,
    input  logic                        last,
    input  logic [IX_W-1:0]             idx,
    input  logic [N_LAGS-1:0][DATA_W-1:0] vec,
    output logic signed [DATA_W-1:0]    peak,
    output logic signed [LAG_OUT_W-1:0] lag
);

    logic signed [N_LAGS-1:0][DATA_W-1:0] snap;
    logic signed [DATA_W-1:0]             best_val;
    logic [IX_W-1:0]                      best_idx;
    logic signed [DATA_W-1:0]             cand;
    logic signed [DATA_W-1:0]             nxt_val;
    logic [IX_W-1:0]                      nxt_idx;
    logic                                 take;

    // Strict greater-than keeps the earliest index on ties, i.e. the most negative lag.
    always_comb begin
        cand    = snap[idx];
        take    = (idx == '0) || (cand > best_val);
        nxt_val = best_val;
        nxt_idx = best_idx;
        if (take) begin
            nxt_val = cand;
            nxt_idx = idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap     <= '0;
            best_val <= '0;
            best_idx <= '0;
            peak     <= '0;
            lag      <= '0;
        end else begin
            if (load) begin
                snap <= vec;
            end
            if (scan) begin
                best_val <= nxt_val;
                best_idx <= nxt_idx;
                if (last) begin
                    peak <= nxt_val;
                    lag  <= LAG_OUT_W'(nxt_idx) - LAG_OUT_W'(DELAY);
                end
            end
        end
    end

endmodule

// File: rtl/xcorr_peak_finder.sv
// rtl/xcorr_peak_finder.sv - snapshots six correlation vectors and reports per-pair peak lag and value
module xcorr_peak_finder
    import xcorr_pkg::*;
#(
    parameter int NUM_BITS_XCORR    = XCORR_W,
    parameter int MAX_SAMPLES_DELAY = MAX_DELAY,
    parameter int LAG_OUT_W         = lag_width(MAX_SAMPLES_DELAY)
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             start,
    input  logic signed [2*MAX_SAMPLES_DELAY:0][NUM_BITS_XCORR-1:0] xCorrIn0,
    input  logic signed [2*MAX_SAMPLES_DELAY:0][NUM_BITS_XCORR-1:0] xCorrIn1,
    input  logic signed [2*MAX_SAMPLES_DELAY:0][NUM_BITS_XCORR-1:0] xCorrIn2,
    input  logic signed [2*MAX_SAMPLES_DELAY:0][NUM_BITS_XCORR-1:0] xCorrIn3,
    input  logic signed [2*MAX_SAMPLES_DELAY:0][NUM_BITS_XCORR-1:0] xCorrIn4,
    input  logic signed [2*MAX_SAMPLES_DELAY:0][NUM_BITS_XCORR-1:0] xCorrIn5,
    output logic signed [NUM_XCORRS-1:0][LAG_OUT_W-1:0]      lagOut,
    output logic signed [NUM_XCORRS-1:0][NUM_BITS_XCORR-1:0] peakOut,
    output logic                                             validOut,
    output logic                                             busy,
    output logic                                             overrun
);

    localparam int N_LAGS = 2*MAX_SAMPLES_DELAY + 1;
    localparam int IX_W   = $clog2(N_LAGS);

    state_t          state, state_nxt;
    logic [IX_W-1:0] idx, idx_nxt;
    logic            load, last, scan, start_q;

    logic [NUM_XCORRS-1:0][N_LAGS-1:0][NUM_BITS_XCORR-1:0] vecs;

    assign vecs = {xCorrIn5, xCorrIn4, xCorrIn3, xCorrIn2, xCorrIn1, xCorrIn0};
    assign scan = (state == ST_SCAN);
    assign busy = scan;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        last      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                last = (idx == IX_W'(N_LAGS - 1));
                if (last) begin
                    idx_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A start held high is one continuous request; only a fresh rising edge during a scan counts as overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx      <= '0;
            validOut <= 1'b0;
            start_q  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            idx      <= idx_nxt;
            validOut <= last;
            start_q  <= start;
            overrun  <= overrun | (scan & start & ~start_q);
        end
    end

    for (genvar g = 0; g < NUM_XCORRS; g++) begin : g_lane
        xcorr_argmax_lane #(
            .DATA_W    (NUM_BITS_XCORR),
            .DELAY     (MAX_SAMPLES_DELAY),
            .LAG_OUT_W (LAG_OUT_W)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .load (load),
            .scan (scan),
            .last (last),
            .idx  (idx),
            .vec  (vecs[g]),
            .peak (peakOut[g]),
            .lag  (lagOut[g])
        );
    end

endmodule

// File: tb/tb_xcorr_peak_finder.sv
// tb/tb_xcorr_peak_finder.sv - directed self-checking bench for xcorr_peak_finder
module tb_xcorr_peak_finder;
    import xcorr_pkg::*;

    logic clk;
    logic rst;
    logic start;
    xcorr_vec_t xin [NUM_XCORRS];
    logic [NUM_XCORRS-1:0][LAG_W-1:0]   lag_o;
    logic [NUM_XCORRS-1:0][XCORR_W-1:0] peak_o;
    logic valid_o, busy_o, overrun_o;

    int checks = 0;
    int failures = 0;

    xcorr_peak_finder dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .xCorrIn0 (xin[0]),
        .xCorrIn1 (xin[1]),
        .xCorrIn2 (xin[2]),
        .xCorrIn3 (xin[3]),
        .xCorrIn4 (xin[4]),
        .xCorrIn5 (xin[5]),
        .lagOut   (lag_o),
        .peakOut  (peak_o),
        .validOut (valid_o),
        .busy     (busy_o),
        .overrun  (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int lag_at(input int i);
        return int'($signed(lag_o[i]));
    endfunction

    function automatic int peak_at(input int i);
        return int'($signed(peak_o[i]));
    endfunction

    task automatic clear_all();
        for (int p = 0; p < NUM_XCORRS; p++) begin
            xin[p] = '0;
        end
    endtask

    // Called at the negedge after the accepting edge; returns cycles until validOut (-1 on timeout).
    task automatic run_scan(input int pulse_at, input bit scramble, output int lat);
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            if (valid_o) begin
                lat = n;
                break;
            end
            if (scramble) begin
                for (int p = 0; p < NUM_XCORRS; p++) begin
                    for (int i = 0; i < NUM_LAGS; i++) begin
                        xin[p][i] = XCORR_W'(500000 + n * 100 + i);
                    end
                end
            end
            start = (n + 1 == pulse_at);
            @(negedge clk);
        end
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    int lat;
    int nvalid;
    int vpos [$];

    initial begin
        rst = 1'b0;
        start = 1'b0;
        clear_all();
        repeat (3) @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_lag0", lag_at(0), 0);
        check("rst_peak0", peak_at(0), 0);
        rst = 1'b1;

        // Mixed patterns across all pairs, including edge-of-range lags and extreme values.
        clear_all();
        xin[0][15] = 1000;
        xin[2][3] = 500;
        xin[2][20] = 500;
        for (int i = 0; i < NUM_LAGS; i++) begin
            xin[3][i] = XCORR_W'(3 * i - 30);
            xin[4][i] = 5;
            xin[5][i] = XCORR_W'(-100 - i);
        end
        xin[4][0] = 1073741823;
        xin[4][11] = -1073741824;
        kick();
        check("busy_after_start", busy_o, 1);
        run_scan(0, 1'b0, lat);
        check("latency_a", lat, 23);
        check("busy_at_valid", busy_o, 0);
        check("lag0_single", lag_at(0), 4);
        check("peak0_single", peak_at(0), 1000);
        check("lag1_zero", lag_at(1), -11);
        check("peak1_zero", peak_at(1), 0);
        check("lag2_tie", lag_at(2), -8);
        check("peak2_tie", peak_at(2), 500);
        check("lag3_ramp", lag_at(3), 11);
        check("peak3_ramp", peak_at(3), 36);
        check("lag4_max", lag_at(4), -11);
        check("peak4_max", peak_at(4), 1073741823);
        check("lag5_neg", lag_at(5), -11);
        check("peak5_neg", peak_at(5), -100);
        @(negedge clk);
        check("valid_one_cycle", valid_o, 0);
        check("lag0_hold", lag_at(0), 4);

        // Inputs change every cycle and a second start arrives mid-scan.
        clear_all();
        xin[0][2] = 77;
        for (int i = 0; i < NUM_LAGS; i++) xin[1][i] = -5;
        kick();
        run_scan(10, 1'b1, lat);
        check("latency_iso", lat, 23);
        check("overrun_set", overrun_o, 1);
        check("lag0_iso", lag_at(0), -9);
        check("peak0_iso", peak_at(0), 77);
        check("lag1_iso", lag_at(1), -11);
        check("peak1_iso", peak_at(1), -5);
        nvalid = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (valid_o) nvalid++;
        end
        check("single_valid_iso", nvalid, 0);

        // Reset in the middle of a scan.
        clear_all();
        xin[0][0] = 5;
        kick();
        repeat (12) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_lag0", lag_at(0), 0);
        check("midrst_peak0", peak_at(0), 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_overrun", overrun_o, 0);
        check("midrst_valid", valid_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        nvalid = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (valid_o) nvalid++;
        end
        check("midrst_no_valid", nvalid, 0);
        for (int i = 0; i < NUM_LAGS; i++) xin[0][i] = -4;
        xin[0][11] = -3;
        kick();
        run_scan(0, 1'b0, lat);
        check("latency_post_rst", lat, 23);
        check("lag0_post_rst", lag_at(0), 0);
        check("peak0_post_rst", peak_at(0), -3);

        // start held high: one result every 24 cycles, no overrun.
        clear_all();
        xin[0][20] = 9;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 80; n++) begin
            if (valid_o) vpos.push_back(n);
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b_count", vpos.size(), 3);
        if (vpos.size() == 3) begin
            check("b2b_first", vpos[0], 23);
            check("b2b_gap1", vpos[1] - vpos[0], 24);
            check("b2b_gap2", vpos[2] - vpos[1], 24);
        end
        check("b2b_overrun", overrun_o, 0);
        check("b2b_lag0", lag_at(0), 9);
        check("b2b_peak0", peak_at(0), 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
